// File: rtl/reg_bank_ctrl.sv
// Sequences the shared color register bank between VGA reads (req/ack) and
// keypad read-modify-write color edits; VGA wins, bounded by a starvation guard.
module reg_bank_ctrl #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 3,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_valid,
   input  logic [ADDR_W-1:0] key_pos,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_data,
   output logic              vga_ack,
   output logic [ADDR_W-1:0] bank_addr_r,
   input  logic [DATA_W-1:0] bank_dat_r,
   output logic [ADDR_W-1:0] bank_addr_w,
   output logic [DATA_W-1:0] bank_dat_w,
   output logic              bank_we,
   output logic [ADDR_W-1:0] last_pos,
   output logic [DATA_W-1:0] last_color,
   output logic [7:0]        drop_cnt,
   output logic              busy
);

   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      VGA_RD,
      KEY_RD,
      KEY_WR
   } state_t;

   state_t              state_q, state_d;
   logic                key_prev_q, key_prev_d;
   logic                key_pend_q, key_pend_d;
   logic [ADDR_W-1:0]   key_addr_q, key_addr_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [7:0]          drop_q, drop_d;
   logic [DATA_W-1:0]   vga_data_q, vga_data_d;
   logic                vga_ack_q, vga_ack_d;
   logic [ADDR_W-1:0]   addr_r_q, addr_r_d;
   logic [ADDR_W-1:0]   addr_w_q, addr_w_d;
   logic [DATA_W-1:0]   dat_w_q, dat_w_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   last_pos_q, last_pos_d;
   logic [DATA_W-1:0]   last_color_q, last_color_d;
   logic                busy_q, busy_d;
   logic                key_evt;
   logic                vga_grant;
   logic                vga_hold;

   assign key_evt   = key_valid & ~key_prev_q;
   assign vga_grant = vga_req & ~vga_ack_q &
                      (~key_pend_q | (starve_q < STARVE_W'(STARVE_MAX)));
   // A request still up in the ack cycle is the requester renewing it, so a
   // pending key waits one cycle instead of slipping in ahead of the guard.
   assign vga_hold  = vga_req & vga_ack_q;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      state_d      = state_q;
      key_prev_d   = key_valid;
      key_pend_d   = key_pend_q;
      key_addr_d   = key_addr_q;
      starve_d     = starve_q;
      drop_d       = drop_q;
      vga_data_d   = vga_data_q;
      vga_ack_d    = 1'b0;
      addr_r_d     = addr_r_q;
      addr_w_d     = addr_w_q;
      dat_w_d      = dat_w_q;
      we_d         = 1'b0;
      last_pos_d   = last_pos_q;
      last_color_d = last_color_q;

      unique case (state_q)
         IDLE: begin
            if (vga_grant) begin
               state_d  = VGA_RD;
               addr_r_d = vga_addr;
               if (key_pend_q) starve_d = starve_q + 1'b1;
            end else if (key_pend_q && !vga_hold) begin
               state_d  = KEY_RD;
               addr_r_d = key_addr_q;
               starve_d = '0;
            end
         end
         VGA_RD: begin
            vga_data_d = bank_dat_r;
            vga_ack_d  = 1'b1;
            state_d    = IDLE;
         end
         KEY_RD: begin
            dat_w_d  = bank_dat_r + 1'b1;
            addr_w_d = key_addr_q;
            we_d     = 1'b1;
            state_d  = KEY_WR;
         end
         KEY_WR: begin
            last_pos_d   = key_addr_q;
            last_color_d = dat_w_q;
            key_pend_d   = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The pending slot frees up during KEY_WR, so an event there is accepted.
      if (key_evt) begin
         if (!key_pend_q || state_q == KEY_WR) begin
            key_pend_d = 1'b1;
            key_addr_d = key_pos;
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (rst) begin
         state_q      <= IDLE;
         key_prev_q   <= 1'b1;
         key_pend_q   <= 1'b0;
         key_addr_q   <= '0;
         starve_q     <= '0;
         drop_q       <= '0;
         vga_data_q   <= '0;
         vga_ack_q    <= 1'b0;
         addr_r_q     <= '0;
         addr_w_q     <= '0;
         dat_w_q      <= '0;
         we_q         <= 1'b0;
         last_pos_q   <= '0;
         last_color_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_prev_q   <= key_prev_d;
         key_pend_q   <= key_pend_d;
         key_addr_q   <= key_addr_d;
         starve_q     <= starve_d;
         drop_q       <= drop_d;
         vga_data_q   <= vga_data_d;
         vga_ack_q    <= vga_ack_d;
         addr_r_q     <= addr_r_d;
         addr_w_q     <= addr_w_d;
         dat_w_q      <= dat_w_d;
         we_q         <= we_d;
         last_pos_q   <= last_pos_d;
         last_color_q <= last_color_d;
         busy_q       <= busy_d;
      end
   end

   assign vga_data    = vga_data_q;
   assign vga_ack     = vga_ack_q;
   assign bank_addr_r = addr_r_q;
   assign bank_addr_w = addr_w_q;
   assign bank_dat_w  = dat_w_q;
   assign bank_we     = we_q;
   assign last_pos    = last_pos_q;
   assign last_color  = last_color_q;
   assign drop_cnt    = drop_q;
   assign busy        = busy_q;

endmodule
